// File: rtl/counter_ud_mod_presc.sv
// Up/down modulo counter with an 8-rate prescaler, synchronous load, terminal-count pulse and output inversion.
// Define COUNTER_SAT_EN to add the sat port, which holds the count at a boundary instead of wrapping.
module counter_ud_mod_presc #(
  parameter int N        = 8,
  parameter int PRESC_W  = 21,
  parameter int TAP_BASE = 0,
  parameter int TAP_STEP = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ud,
  input  logic         inv,
  input  logic [2:0]   fsel,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic [N-1:0] max,
`ifdef COUNTER_SAT_EN
  input  logic         sat,
`endif
  output logic [N-1:0] q,
  output logic         tc
);

  logic [N-1:0]       r_q, r_d;
  logic [PRESC_W-1:0] p_q, p_d;
  logic               tc_q, tc_d;
  logic               sat_mode;
  logic               tick;
  logic [PRESC_W-1:0] tap_mask [8];

`ifdef COUNTER_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  // One low-bits mask per rate: a tick fires when the low k prescaler bits are all ones.
  for (genvar gi = 0; gi < 8; gi++) begin : g_tap
    localparam int K = TAP_BASE + TAP_STEP * gi;
    localparam logic [PRESC_W:0] ONE_W = (PRESC_W + 1)'(1);
    localparam logic [PRESC_W:0] FULL  = (ONE_W << K) - ONE_W;
    assign tap_mask[gi] = FULL[PRESC_W-1:0];
  end

  assign tick = en & ((p_q & tap_mask[fsel]) == tap_mask[fsel]);

  always_comb begin
    r_d  = r_q;
    tc_d = 1'b0;
    p_d  = en ? p_q + PRESC_W'(1) : p_q;
    if (load) begin
      r_d = (din > max) ? max : din;
    end else if (tick) begin
      if (ud) begin
        if (r_q >= max) begin
          tc_d = 1'b1;
          r_d  = sat_mode ? r_q : '0;
        end else begin
          r_d = r_q + N'(1);
        end
      end else begin
        // A count left above a lowered max still walks down one step at a time.
        if (r_q == '0) begin
          tc_d = 1'b1;
          r_d  = sat_mode ? r_q : max;
        end else begin
          r_d = r_q - N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q  <= '0;
      p_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      p_q  <= p_d;
      tc_q <= tc_d;
    end
  end

  assign q  = inv ? ~r_q : r_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_counter_ud_mod_presc.sv
// Scoreboard bench for counter_ud_mod_presc: the driver pushes expected outputs from an arithmetic model,
// and a monitor compares them one cycle later.
module tb_counter_ud_mod_presc;

  localparam int N        = 8;
  localparam int PRESC_W  = 21;
  localparam int TAP_BASE = 0;
  localparam int TAP_STEP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, ud = 1'b1, inv = 1'b1, load = 1'b0, sat = 1'b0;
  logic [2:0]   fsel = 3'd0;
  logic [N-1:0] din = '0, max = 8'hFF;
  logic [N-1:0] q;
  logic         tc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] q;
    logic         tc;
    int           id;
  } exp_t;
  exp_t sb[$];

  // Reference state: count value, number of enabled cycles seen, last tc.
  int     m_r = 0;
  longint m_p = 0;
  int     m_tc = 0;
  int     txn = 0;

  counter_ud_mod_presc #(
    .N(N), .PRESC_W(PRESC_W), .TAP_BASE(TAP_BASE), .TAP_STEP(TAP_STEP)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ud(ud), .inv(inv), .fsel(fsel),
    .load(load), .din(din), .max(max),
`ifdef COUNTER_SAT_EN
    .sat(sat),
`endif
    .q(q), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic model_reset();
    m_r = 0;
    m_p = 0;
    m_tc = 0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the following edge.
  task automatic drive(input logic e, input logic u, input logic i, input logic [2:0] fs,
                       input logic ld, input logic [N-1:0] d, input logic [N-1:0] mx,
                       input logic s);
    int     k;
    longint period;
    bit     tk;
    bit     sat_on;
    exp_t   x;
    @(negedge clk);
    en = e; ud = u; inv = i; fsel = fs; load = ld; din = d; max = mx; sat = s;
`ifdef COUNTER_SAT_EN
    sat_on = s;
`else
    sat_on = 1'b0;
`endif
    k = TAP_BASE + TAP_STEP * int'(fs);
    period = longint'(1) << k;
    tk = e && ((m_p % period) == period - 1);
    if (ld) begin
      m_r = (int'(d) > int'(mx)) ? int'(mx) : int'(d);
      m_tc = 0;
    end else if (tk && u) begin
      if (m_r >= int'(mx)) begin
        m_tc = 1;
        if (!sat_on) m_r = 0;
      end else begin
        m_r = m_r + 1;
        m_tc = 0;
      end
    end else if (tk) begin
      if (m_r == 0) begin
        m_tc = 1;
        if (!sat_on) m_r = int'(mx);
      end else begin
        m_r = m_r - 1;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
    if (e) m_p = (m_p + 1) % (longint'(1) << PRESC_W);
    txn++;
    x.q  = i ? ~N'(m_r) : N'(m_r);
    x.tc = (m_tc != 0);
    x.id = txn;
    sb.push_back(x);
  endtask

  // Monitor: the counter presents a result on every edge, so pop once per edge while work is pending.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (q !== x.q || tc !== x.tc) begin
          errors++;
          $display("FAIL txn%0d: q=%0h tc=%0b, expected q=%0h tc=%0b", x.id, q, tc, x.q, x.tc);
        end else begin
          $display("txn%0d q=%0h tc=%0b", x.id, q, tc);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rmax;
    // Reset state, with inversion following inv combinationally.
    #12;
    check("reset_q_inv1", int'(q), 8'hFF);
    check("reset_tc", int'(tc), 0);
    inv = 1'b0;
    #1;
    check("reset_q_inv0", int'(q), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Full-range up count at the fastest rate wraps 0xFF->0x00 with one tc.
    for (int i = 0; i < 258; i++) drive(1, 1, 0, 3'd0, 0, 8'h00, 8'hFF, 0);

    // Modulo-10 down count starting from 0.
    drive(0, 0, 0, 3'd0, 1, 8'h00, 8'd9, 0);
    for (int i = 0; i < 22; i++) drive(1, 0, 0, 3'd0, 0, 8'h00, 8'd9, 0);

    // Slow rate with a long pause mid-period.
    for (int i = 0; i < 90; i++)  drive(1, 1, 0, 3'd2, 0, 8'h00, 8'hFF, 0);
    for (int i = 0; i < 100; i++) drive(0, 1, 0, 3'd2, 0, 8'h00, 8'hFF, 0);
    for (int i = 0; i < 110; i++) drive(1, 1, 0, 3'd2, 0, 8'h00, 8'hFF, 0);

    // Clamped load while paused, then load colliding with a tick.
    drive(0, 1, 0, 3'd0, 1, 8'd200, 8'd150, 0);
    drive(0, 1, 0, 3'd0, 0, 8'd0, 8'd150, 0);
    drive(1, 1, 0, 3'd0, 1, 8'd42, 8'd150, 0);
    drive(1, 1, 0, 3'd0, 0, 8'd0, 8'd150, 0);

    // Inversion toggles leave the count alone.
    drive(0, 1, 0, 3'd0, 1, 8'h0F, 8'hFF, 0);
    drive(0, 1, 1, 3'd0, 0, 8'h00, 8'hFF, 0);
    drive(0, 1, 0, 3'd0, 0, 8'h00, 8'hFF, 0);

    // Lowering max below the count while counting down.
    drive(0, 0, 0, 3'd0, 1, 8'd200, 8'hFF, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 3'd0, 0, 8'h00, 8'd20, 0);

`ifdef COUNTER_SAT_EN
    drive(0, 1, 0, 3'd0, 1, 8'd0, 8'd5, 1);
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 3'd0, 0, 8'd0, 8'd5, 1);
    for (int i = 0; i < 8; i++)  drive(1, 0, 0, 3'd0, 0, 8'd0, 8'd5, 1);
`endif

    // Randomised traffic over every control.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       rmax = 8'hFF;
        1:       rmax = 8'($urandom_range(0, 12));
        default: rmax = 8'($urandom_range(0, 255));
      endcase
      if (i % 50 != 0) rmax = max;
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
            3'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            8'($urandom), (i == 0) ? 8'd9 : rmax, 1'($urandom));
    end

    // Asynchronous reset in the middle of counting acts without a clock edge.
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 3'd0, 0, 8'h00, 8'hFF, 0);
    @(posedge clk);
    #3;
    en = 1'b0; load = 1'b0; inv = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_q", int'(q), 0);
    check("midreset_tc", int'(tc), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 3'd0, 0, 8'h00, 8'hFF, 0);

    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
